wishbone_rr_arbiter: RTL

//  Grant controller for the shared Wishbone bus; replaces fixed-priority master selection.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_rr_pick.sv | 27 ++
 rtl/wishbone_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and width helpers for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the
// last-granted index, wrapping around to index 0.
module wb_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] pick
);

    localparam logic [N-1:0]   ONE_N  = 1;
    localparam logic [2*N-1:0] ONE_2N = 1;

    logic [N-1:0]   higher;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_pick;

    // Lower copy only keeps requesters above the last grant; the upper copy
    // supplies the wrap-around, so the lowest set bit of the pair is the winner.
    always_comb begin
        higher   = ~((last << 1) - ONE_N);
        dbl      = {req, req & higher};
        dbl_pick = dbl & (~dbl + ONE_2N);
        pick     = dbl_pick[N-1:0] | dbl_pick[2*N-1:N];
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin grant controller for the shared Wishbone bus: holds a grant for
// the whole cyc, counts outstanding pipelined requests, throttles at a limit
// and aborts a tenure whose slave stops answering.
module wishbone_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTER      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_MASTER-1:0] cyc_i,
    input  logic [NUM_MASTER-1:0] stb_i,
    input  logic                  stall_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    output logic [NUM_MASTER-1:0] gnt_o,
    output logic                  stall_o,
    output logic                  stb_en_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  timeout_o
);

    localparam int OUT_W = cnt_width(MAX_OUTSTANDING);
    localparam int TMR_W = cnt_width(TIMEOUT_CYCLES);

    localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0]      TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [NUM_MASTER-1:0] ONE_M    = 1;
    localparam logic [NUM_MASTER-1:0] LAST_RST = ONE_M << (NUM_MASTER - 1);

    arb_state_e            state_q, state_d;
    logic [NUM_MASTER-1:0] gnt_q, gnt_d;
    logic [NUM_MASTER-1:0] last_q, last_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [NUM_MASTER-1:0] pick;

    logic granted_cyc, granted_stb, in_grant;
    logic resp_ok, timeout_hit, throttled, accept;

    wb_rr_pick #(.N(NUM_MASTER)) u_pick (
        .req  (cyc_i),
        .last (last_q),
        .pick (pick)
    );

    // Output gating; a response retiring this cycle frees a slot immediately,
    // so a full pipeline can accept and retire in the same cycle.
    always_comb begin
        granted_cyc = |(cyc_i & gnt_q);
        granted_stb = |(stb_i & gnt_q);
        in_grant    = (state_q == GRANT);
        resp_ok     = in_grant & (ack_i | err_i) & (out_q != '0);
        timeout_hit = in_grant & (tmr_q == TMR_MAX);
        throttled   = (out_q == OUT_MAX) & ~resp_ok;
        stall_o     = ~in_grant | stall_i | throttled;
        stb_en_o    = in_grant & ~throttled;
        accept      = granted_cyc & granted_stb & stb_en_o & ~stall_o;
        ack_o       = resp_ok & ack_i & ~timeout_hit;
        err_o       = (resp_ok & err_i & ~timeout_hit) | timeout_hit;
        timeout_o   = timeout_hit;
        gnt_o       = gnt_q;
    end

    // Next-state: grant selection, tenure end, outstanding count and timer.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        out_d   = out_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                out_d = '0;
                tmr_d = '0;
                if (|cyc_i) begin
                    gnt_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!granted_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_q;
                    out_d   = '0;
                    tmr_d   = '0;
                end else if (timeout_hit) begin
                    state_d = ABORT;
                    out_d   = '0;
                    tmr_d   = '0;
                end else begin
                    out_d = out_q + OUT_W'(accept) - OUT_W'(resp_ok);
                    tmr_d = ((out_q != '0) && !resp_ok) ? tmr_q + TMR_W'(1) : '0;
                end
            end
            ABORT: begin
                out_d = '0;
                tmr_d = '0;
                if (!granted_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                out_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // State registers; the pointer resets to the top master so master 0 wins first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            out_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            out_q   <= out_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule
